// File: rtl/freqdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
// The board clock is 50 MHz, so the half-period is CLK_HZ / (2 * target_hz).
package freqdiv_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned HALF_10HZ = 2_500_000;
  localparam int unsigned HALF_1HZ  = 25_000_000;

  // The order of these items follows the priority sync > disabled > terminal count > count.
  typedef enum logic [1:0] {
    ACT_COUNT,
    ACT_TOGGLE,
    ACT_IDLE,
    ACT_SYNC
  } chan_act_e;

  function automatic int unsigned half_for(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/freqdiv_chan.sv
// One divider channel: counter, active and shadow half-period, square-wave output and rising-edge tick.
// Reprogramming is double-buffered so a running half-period is never cut short.
module freqdiv_chan
  import freqdiv_pkg::*;
#(
  parameter int unsigned W            = 25,
  parameter int unsigned HALF_DEFAULT = HALF_10HZ,
  parameter logic        INIT_LEVEL   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         wr_stb,
  input  logic [W-1:0] wr_half,
  output logic         clk_out,
  output logic         tick,
  output logic         pending
);

  localparam logic [W-1:0] HALF_RST = W'(HALF_DEFAULT);

  logic [W-1:0] cnt;
  logic [W-1:0] half;
  logic [W-1:0] shadow;
  logic [W-1:0] wr_val;
  logic [W-1:0] term;
  chan_act_e    act;

  // A zero half-period would never reach terminal count, so it is clamped to one.
  assign wr_val = (wr_half == '0) ? W'(1) : wr_half;
  assign term   = half - W'(1);

  always_comb begin
    act = ACT_COUNT;
    if (sync) begin
      act = ACT_SYNC;
    end else if (!en) begin
      act = ACT_IDLE;
    end else if (cnt == term) begin
      act = ACT_TOGGLE;
    end
  end

  // A write can only arrive while pending is clear, so commit and capture never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      half    <= HALF_RST;
      shadow  <= HALF_RST;
      pending <= 1'b0;
      clk_out <= INIT_LEVEL;
      tick    <= 1'b0;
    end else begin
      unique case (act)
        ACT_SYNC: begin
          cnt     <= '0;
          clk_out <= INIT_LEVEL;
          tick    <= 1'b0;
          pending <= 1'b0;
          if (wr_stb) begin
            half <= wr_val;
          end else if (pending) begin
            half <= shadow;
          end
        end
        ACT_IDLE: begin
          cnt  <= '0;
          tick <= 1'b0;
          if (wr_stb) begin
            half <= wr_val;
          end
        end
        ACT_TOGGLE: begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          if (pending) begin
            half    <= shadow;
            pending <= 1'b0;
          end else if (wr_stb) begin
            shadow  <= wr_val;
            pending <= 1'b1;
          end
        end
        ACT_COUNT: begin
          cnt  <= cnt + W'(1);
          tick <= 1'b0;
          if (wr_stb) begin
            shadow  <= wr_val;
            pending <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/freqdiv_multi.sv
// N-channel programmable clock divider with a shared valid/ready configuration port.
// The top only routes config writes to channels and reports the selected channel's readiness.
module freqdiv_multi
  import freqdiv_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned W            = 25,
  parameter int unsigned HALF_DEFAULT = HALF_10HZ,
  parameter logic        INIT_LEVEL   = 1'b1,
  localparam int unsigned CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CW-1:0]   cfg_chan,
  input  logic [W-1:0]    cfg_half,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick
);

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] wr_stb;

  // Channel numbers with no matching channel stay ready so a stray write is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_chan == CW'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign wr_stb[i] = cfg_valid & cfg_ready & (cfg_chan == CW'(i));

    freqdiv_chan #(
      .W            (W),
      .HALF_DEFAULT (HALF_DEFAULT),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr_stb  (wr_stb[i]),
      .wr_half (cfg_half),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule
